fwd_scoreboard: RTL and testbench

//  Parametrised forwarding and load-use hazard unit for the MIPS pipeline.

---
 rtl/fwd_scoreboard.sv | 110 +++++++++++
 tb/tb_fwd_scoreboard.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: tracks in-flight producers, picks the
// youngest forwarding source per operand port and stalls on not-yet-ready loads.
module fwd_scoreboard #(
    parameter int REG_ADDR_SIZE = 5,
    parameter int N_READ        = 2,
    parameter int FWD_DEPTH     = 3,
    parameter int LOAD_LAT      = 1,
    localparam int SEL_W        = $clog2(FWD_DEPTH + 1)
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_enable,
    input  logic                            i_flush,
    input  logic                            i_issue_valid,
    input  logic                            i_issue_wb,
    input  logic                            i_issue_is_load,
    input  logic [REG_ADDR_SIZE-1:0]        i_issue_addr,
    input  logic [N_READ*REG_ADDR_SIZE-1:0] i_rd_addr,
    output logic [N_READ*SEL_W-1:0]         o_fwd_sel,
    output logic                            o_stall,
    output logic [15:0]                     o_stall_cycles
);

    logic [FWD_DEPTH-1:0]                    slot_valid_r;
    logic [FWD_DEPTH-1:0]                    slot_wb_r;
    logic [FWD_DEPTH-1:0]                    slot_load_r;
    logic [FWD_DEPTH-1:0][REG_ADDR_SIZE-1:0] slot_addr_r;
    logic [15:0]                             stall_cycles_r;

    logic [FWD_DEPTH-1:0]                    slot_ready_s;
    logic [N_READ-1:0][SEL_W-1:0]            sel_s;
    logic [N_READ-1:0]                       req_s;
    logic                                    stall_s;
    logic                                    push_s;

    // A loaded value becomes forwardable once it has travelled LOAD_LAT slots.
    always_comb begin
        slot_ready_s = '0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            slot_ready_s[k] = !slot_load_r[k] || (k >= LOAD_LAT);
        end
    end

    // Per-port source select; scanning oldest to youngest lets the nearest
    // match overwrite, so a not-ready young load can never be bypassed.
    always_comb begin
        sel_s = '0;
        req_s = '0;
        for (int r = 0; r < N_READ; r++) begin
            for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
                if ((i_rd_addr[r*REG_ADDR_SIZE +: REG_ADDR_SIZE] != '0) &&
                    slot_valid_r[k] && slot_wb_r[k] &&
                    (slot_addr_r[k] == i_rd_addr[r*REG_ADDR_SIZE +: REG_ADDR_SIZE])) begin
                    if (slot_ready_s[k]) begin
                        sel_s[r] = SEL_W'(k + 1);
                        req_s[r] = 1'b0;
                    end else begin
                        sel_s[r] = '0;
                        req_s[r] = 1'b1;
                    end
                end else begin
                    sel_s[r] = sel_s[r];
                    req_s[r] = req_s[r];
                end
            end
        end
    end

    // Stall gating and slot-0 admission.
    always_comb begin
        stall_s = i_issue_valid && (|req_s);
        push_s  = i_issue_valid && !stall_s && !i_flush;
    end

    assign o_fwd_sel      = sel_s;
    assign o_stall        = stall_s;
    assign o_stall_cycles = stall_cycles_r;

    // Producer pipeline; a flush kills both the issuing instruction and the
    // one leaving slot 0, since both sit on the wrong path.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            slot_valid_r <= '0;
            slot_wb_r    <= '0;
            slot_load_r  <= '0;
            slot_addr_r  <= '0;
        end else if (i_enable) begin
            for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
                slot_valid_r[k] <= slot_valid_r[k-1] && !(i_flush && (k == 1));
                slot_wb_r[k]    <= slot_wb_r[k-1];
                slot_load_r[k]  <= slot_load_r[k-1];
                slot_addr_r[k]  <= slot_addr_r[k-1];
            end
            slot_valid_r[0] <= push_s;
            slot_wb_r[0]    <= i_issue_wb;
            slot_load_r[0]  <= i_issue_is_load;
            slot_addr_r[0]  <= i_issue_addr;
        end
    end

    // Saturating stall-cycle counter; flush cycles are not counted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stall_cycles_r <= 16'h0000;
        end else if (i_enable && stall_s && !i_flush && (stall_cycles_r != 16'hFFFF)) begin
            stall_cycles_r <= stall_cycles_r + 16'h0001;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed table-driven bench for fwd_scoreboard, plus reset and counter
// saturation sequences on a deep-pipeline second instance.
module tb_fwd_scoreboard;

    localparam int RAS    = 5;
    localparam int SEL_W  = 2;
    localparam int SEL_W2 = 5;

    typedef struct {
        int en, fl, v, w, l, ia, r0, r1;
        int s0, s1, st, cnt;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              en, fl, iv, iw, il;
    logic [RAS-1:0]    ia;
    logic [2*RAS-1:0]  rd;
    logic [2*SEL_W-1:0] sel;
    logic              stall;
    logic [15:0]       cnt;

    logic              en2;
    logic [2*SEL_W2-1:0] sel2;
    logic              stall2;
    logic [15:0]       cnt2;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fwd_scoreboard dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_flush(fl),
        .i_issue_valid(iv), .i_issue_wb(iw), .i_issue_is_load(il),
        .i_issue_addr(ia), .i_rd_addr(rd),
        .o_fwd_sel(sel), .o_stall(stall), .o_stall_cycles(cnt)
    );

    // Deep pipeline: a load that reads its own destination re-stalls every time.
    fwd_scoreboard #(.FWD_DEPTH(16), .LOAD_LAT(15)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_enable(en2), .i_flush(1'b0),
        .i_issue_valid(1'b1), .i_issue_wb(1'b1), .i_issue_is_load(1'b1),
        .i_issue_addr(5'd4), .i_rd_addr({5'd4, 5'd4}),
        .o_fwd_sel(sel2), .o_stall(stall2), .o_stall_cycles(cnt2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int en_v, fl_v, v_v, w_v, l_v, ia_v, r0_v, r1_v,
                       s0_v, s1_v, st_v, cnt_v);
        vec_t t;
        t = '{en_v, fl_v, v_v, w_v, l_v, ia_v, r0_v, r1_v, s0_v, s1_v, st_v, cnt_v};
        vecs.push_back(t);
    endtask

    initial begin
        //   en fl v  w  l  ia  r0 r1 | s0 s1 st cnt
        add(1, 0, 1, 1, 0, 3,  0, 0,  0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 9,  3, 1,  1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 10, 3, 3,  2, 2, 0, 0);
        add(1, 0, 0, 0, 0, 0,  3, 9,  3, 2, 0, 0);
        add(1, 0, 0, 0, 0, 0,  3, 9,  0, 3, 0, 0);
        add(1, 0, 1, 1, 1, 4,  0, 0,  0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 6,  4, 2,  0, 0, 1, 0);
        add(1, 0, 1, 1, 0, 6,  4, 2,  2, 0, 0, 1);
        add(1, 0, 1, 1, 0, 7,  4, 6,  3, 1, 0, 1);
        add(1, 0, 1, 1, 0, 7,  0, 0,  0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0,  7, 7,  1, 1, 0, 1);
        add(1, 0, 1, 1, 0, 0,  7, 0,  2, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0,  0, 7,  0, 3, 0, 1);
        add(1, 0, 1, 1, 1, 2,  0, 0,  0, 0, 0, 1);
        add(1, 1, 1, 1, 0, 8,  2, 2,  0, 0, 1, 1);
        add(1, 0, 1, 1, 0, 8,  2, 2,  0, 0, 0, 1);
        add(1, 0, 1, 1, 1, 5,  0, 0,  0, 0, 0, 1);
        add(0, 0, 1, 1, 0, 11, 5, 8,  0, 2, 1, 1);
        add(0, 0, 1, 1, 0, 11, 8, 5,  2, 0, 1, 1);
        add(0, 0, 1, 1, 0, 11, 5, 8,  0, 2, 1, 1);
        add(1, 0, 1, 1, 0, 11, 5, 8,  0, 2, 1, 1);
        add(1, 0, 1, 1, 0, 11, 5, 8,  2, 3, 0, 2);
        add(1, 0, 1, 1, 1, 12, 0, 0,  0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0, 12, 11, 0, 2, 0, 2);
        add(1, 0, 0, 0, 0, 0, 12, 11, 2, 3, 0, 2);

        rst = 1'b1; en = 1'b1; fl = 1'b0; iv = 1'b0; iw = 1'b0; il = 1'b0;
        ia = '0; rd = {5'd5, 5'd5}; en2 = 1'b0;
        @(negedge clk); #1;
        chk("reset sel0", int'(sel[1:0]), 0);
        chk("reset sel1", int'(sel[3:2]), 0);
        chk("reset stall", int'(stall), 0);
        chk("reset cnt", int'(cnt), 0);
        rst = 1'b0;
        rd = '0;

        foreach (vecs[i]) begin
            @(negedge clk);
            en = 1'(vecs[i].en); fl = 1'(vecs[i].fl); iv = 1'(vecs[i].v);
            iw = 1'(vecs[i].w);  il = 1'(vecs[i].l);  ia = RAS'(vecs[i].ia);
            rd = {RAS'(vecs[i].r1), RAS'(vecs[i].r0)};
            #1;
            chk($sformatf("row%0d sel0", i), int'(sel[1:0]), vecs[i].s0);
            chk($sformatf("row%0d sel1", i), int'(sel[3:2]), vecs[i].s1);
            chk($sformatf("row%0d stall", i), int'(stall), vecs[i].st);
            chk($sformatf("row%0d cnt", i), int'(cnt), vecs[i].cnt);
        end

        // Mid-operation reset drops the in-flight load in slot 2.
        @(negedge clk);
        en = 1'b1; fl = 1'b0; iv = 1'b0; iw = 1'b0; il = 1'b0;
        rd = {5'd12, 5'd12};
        #1;
        chk("pre-reset sel0", int'(sel[1:0]), 3);
        rst = 1'b1;
        #1;
        chk("midreset sel0", int'(sel[1:0]), 0);
        chk("midreset sel1", int'(sel[3:2]), 0);
        chk("midreset stall", int'(stall), 0);
        chk("midreset cnt", int'(cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postreset sel0", int'(sel[1:0]), 0);

        // 15 stall cycles every 16 edges on the deep instance.
        @(negedge clk);
        en2 = 1'b1;
        repeat (160) @(negedge clk);
        #1;
        chk("sat cnt@160", int'(cnt2), 150);
        repeat (69903 - 160) @(negedge clk);
        #1;
        chk("sat cnt@69903", int'(cnt2), 65534);
        @(negedge clk); #1;
        chk("sat cnt@69904", int'(cnt2), 65535);
        repeat (40) @(negedge clk);
        #1;
        chk("sat hold", int'(cnt2), 65535);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
